// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder slice.
package data_mem_responder_pkg;

    localparam int unsigned DEFAULT_LATENCY = 3;
    localparam int unsigned DEFAULT_DEPTH   = 256;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned BYTE_OFF_W      = 2;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage request/response bundle between the pipeline and the data memory.
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic              memread;
    logic              memwrite;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] readdata;
    logic              stall;
    logic              done;
    logic              err;

    modport master (
        output memread, memwrite, addr, wdata,
        input  readdata, stall, done, err
    );

    modport slave (
        input  memread, memwrite, addr, wdata,
        output readdata, stall, done, err
    );

endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// Word storage: synchronous write, asynchronous read, never cleared by reset.
module dmem_array
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Commit a word on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: stalls the pipeline for LATENCY cycles
// per access, then pulses done (and err for bad accesses) for one cycle.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY = DEFAULT_LATENCY,
    parameter int unsigned DEPTH   = DEFAULT_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]  wdata_q, wdata_d;
    logic               wr_q, wr_d;
    logic               misal_q, misal_d;
    logic               conflict_q, conflict_d;
    logic [WORD_W-1:0]  readdata_q, readdata_d;
    logic               err_q, err_d;

    logic               req;
    logic               stall;
    logic               mem_we;
    logic [WORD_W-1:0]  mem_rdata;
    logic               unused_addr_hi;

    assign req            = bus.memread | bus.memwrite;
    assign unused_addr_hi = ^bus.addr[WORD_W-1:IDX_W+BYTE_OFF_W];

    // Capture the request fields while idle; hold them for the rest of the access.
    // The _d values double as the "current access" so LATENCY=1 can commit
    // on the very edge that leaves IDLE.
    always_comb begin
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        misal_d    = misal_q;
        conflict_d = conflict_q;
        if (state_q == ST_IDLE) begin
            idx_d      = bus.addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
            wdata_d    = bus.wdata;
            wr_d       = bus.memwrite;
            misal_d    = |bus.addr[BYTE_OFF_W-1:0];
            conflict_d = bus.memread & bus.memwrite;
        end
    end

    // Next-state, stall, write enable and response registers
    always_comb begin
        logic enter_resp;
        state_d    = state_q;
        cnt_d      = cnt_q;
        readdata_d = readdata_q;
        err_d      = 1'b0;
        stall      = 1'b0;
        enter_resp = 1'b0;
        mem_we     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    stall = 1'b1;
                    if (LATENCY > 1) begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end else begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_resp) begin
            err_d = misal_d | conflict_d;
            if (wr_d) begin
                mem_we = ~misal_d & ~rst;
            end else begin
                readdata_d = misal_d ? '0 : mem_rdata;
            end
        end
    end

    // State and datapath registers with synchronous reset (storage untouched)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            misal_q    <= 1'b0;
            conflict_q <= 1'b0;
            readdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            misal_q    <= misal_d;
            conflict_q <= conflict_d;
            readdata_q <= readdata_d;
            err_q      <= err_d;
        end
    end

    dmem_array #(
        .DEPTH(DEPTH)
    ) u_dmem_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (idx_d),
        .wdata (wdata_d),
        .rdata (mem_rdata)
    );

    assign bus.readdata = readdata_q;
    assign bus.stall    = stall;
    assign bus.done     = (state_q == ST_RESP);
    assign bus.err      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=3 and LATENCY=1 instances.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder_if bus0();
    data_mem_responder_if bus1();

    data_mem_responder #(.LATENCY(3), .DEPTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    data_mem_responder #(.LATENCY(1), .DEPTH(256)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus0.memread = rd; bus0.memwrite = wr; bus0.addr = a; bus0.wdata = d;
        end else begin
            bus1.memread = rd; bus1.memwrite = wr; bus1.addr = a; bus1.wdata = d;
        end
    endtask

    // Issue one access starting at posedge+1; returns at posedge+1 of the cycle after RESP.
    task automatic do_access(input int sel, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] d,
                             output int stalls, output int done_at, output logic err_at,
                             output logic [31:0] rdata_at, output logic stall_at,
                             output int done_cyc);
        logic s, dn;
        drive(sel, rd, wr, a, d);
        stalls = 0; done_at = -1; err_at = 1'bx; rdata_at = 'x; stall_at = 1'bx; done_cyc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            s  = (sel == 0) ? bus0.stall : bus1.stall;
            dn = (sel == 0) ? bus0.done  : bus1.done;
            if (s === 1'b1) stalls++;
            if (dn === 1'b1) begin
                done_at  = k;
                done_cyc = cyc;
                stall_at = s;
                err_at   = (sel == 0) ? bus0.err : bus1.err;
                rdata_at = (sel == 0) ? bus0.readdata : bus1.readdata;
                break;
            end
        end
        next_cycle();
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++; if (bus0.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus0.stall); end
        n_tests++; if (bus0.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus0.done); end
        n_tests++; if (bus0.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus0.err); end
        n_tests++; if (bus0.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got %h expected 0", bus0.readdata); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        int st, dat, dc; logic e, sa; logic [31:0] rd;
        do_access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, st, dat, e, rd, sa, dc);
        n_tests++; if (st !== 3) begin n_fail++; $display("FAIL wr_stall_cycles: got %0d expected 3", st); end
        n_tests++; if (dat !== 3) begin n_fail++; $display("FAIL wr_done_cycle: got %0d expected 3", dat); end
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b expected 0", e); end
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wr_readdata_unchanged: got %h expected 0", rd); end
        @(negedge clk);
        n_tests++; if (bus0.done !== 1'b0) begin n_fail++; $display("FAIL done_single_pulse: got %b expected 0", bus0.done); end
        next_cycle();
        do_access(0, 1'b1, 1'b0, 32'h10, 32'h0, st, dat, e, rd, sa, dc);
        n_tests++; if (st !== 3) begin n_fail++; $display("FAIL rd_stall_cycles: got %0d expected 3", st); end
        n_tests++; if (dat !== 3) begin n_fail++; $display("FAIL rd_done_cycle: got %0d expected 3", dat); end
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
        // 0x410 aliases word 4 with DEPTH=256
        do_access(0, 1'b1, 1'b0, 32'h410, 32'h0, st, dat, e, rd, sa, dc);
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_wrap: got %h expected deadbeef", rd); end
    endtask

    task automatic test_back_to_back();
        int st, dat, dc1, dc2; logic e, sa; logic [31:0] rd1, rd2;
        do_access(0, 1'b0, 1'b1, 32'h20, 32'h20202020, st, dat, e, rd1, sa, dc1);
        do_access(0, 1'b0, 1'b1, 32'h24, 32'h24242424, st, dat, e, rd1, sa, dc1);
        do_access(0, 1'b1, 1'b0, 32'h20, 32'h0, st, dat, e, rd1, sa, dc1);
        n_tests++; if (sa !== 1'b0) begin n_fail++; $display("FAIL b2b_resp_stall: got %b expected 0", sa); end
        do_access(0, 1'b1, 1'b0, 32'h24, 32'h0, st, dat, e, rd2, sa, dc2);
        n_tests++; if (st !== 3) begin n_fail++; $display("FAIL b2b_second_stall: got %0d expected 3", st); end
        n_tests++; if (dc2 - dc1 !== 4) begin n_fail++; $display("FAIL b2b_done_spacing: got %0d expected 4", dc2 - dc1); end
        n_tests++; if (rd1 !== 32'h20202020) begin n_fail++; $display("FAIL b2b_rd0: got %h expected 20202020", rd1); end
        n_tests++; if (rd2 !== 32'h24242424) begin n_fail++; $display("FAIL b2b_rd1: got %h expected 24242424", rd2); end
    endtask

    task automatic test_misaligned();
        int st, dat, dc; logic e, sa; logic [31:0] rd;
        do_access(0, 1'b0, 1'b1, 32'h13, 32'h12345678, st, dat, e, rd, sa, dc);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL mis_wr_err: got %b expected 1", e); end
        n_tests++; if (dat !== 3) begin n_fail++; $display("FAIL mis_wr_done_cycle: got %0d expected 3", dat); end
        n_tests++; if (rd !== 32'h24242424) begin n_fail++; $display("FAIL mis_wr_readdata_hold: got %h expected 24242424", rd); end
        do_access(0, 1'b1, 1'b0, 32'h10, 32'h0, st, dat, e, rd, sa, dc);
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mis_no_write: got %h expected deadbeef", rd); end
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL aligned_rd_err: got %b expected 0", e); end
        do_access(0, 1'b1, 1'b0, 32'h11, 32'h0, st, dat, e, rd, sa, dc);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mis_rd_data: got %h expected 0", rd); end
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL mis_rd_err: got %b expected 1", e); end
    endtask

    task automatic test_conflict();
        int st, dat, dc; logic e, sa; logic [31:0] rd;
        do_access(0, 1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, st, dat, e, rd, sa, dc);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL both_err: got %b expected 1", e); end
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL both_readdata_hold: got %h expected 0", rd); end
        do_access(0, 1'b1, 1'b0, 32'h40, 32'h0, st, dat, e, rd, sa, dc);
        n_tests++; if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL both_is_write: got %h expected a5a5a5a5", rd); end
    endtask

    task automatic test_reset_abort();
        int st, dat, dc; logic e, sa; logic [31:0] rd;
        do_access(0, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D, st, dat, e, rd, sa, dc);
        drive(0, 1'b0, 1'b1, 32'h8, 32'h11111111);
        next_cycle();
        @(negedge clk);
        n_tests++; if (bus0.stall !== 1'b1) begin n_fail++; $display("FAIL abort_busy_stall: got %b expected 1", bus0.stall); end
        next_cycle();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (bus0.stall !== 1'b0) begin n_fail++; $display("FAIL abort_stall: got %b expected 0", bus0.stall); end
        n_tests++; if (bus0.done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", bus0.done); end
        n_tests++; if (bus0.readdata !== 32'h0) begin n_fail++; $display("FAIL abort_readdata: got %h expected 0", bus0.readdata); end
        next_cycle();
        do_access(0, 1'b1, 1'b0, 32'h8, 32'h0, st, dat, e, rd, sa, dc);
        n_tests++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL abort_discard: got %h expected cafef00d", rd); end
        n_tests++; if (dat !== 3) begin n_fail++; $display("FAIL abort_next_done_cycle: got %0d expected 3", dat); end
    endtask

    task automatic test_latency1_wrap();
        int st, dat, dc; logic e, sa; logic [31:0] rd;
        do_access(1, 1'b0, 1'b1, 32'h404, 32'h77, st, dat, e, rd, sa, dc);
        n_tests++; if (st !== 1) begin n_fail++; $display("FAIL l1_wr_stall: got %0d expected 1", st); end
        n_tests++; if (dat !== 1) begin n_fail++; $display("FAIL l1_wr_done_cycle: got %0d expected 1", dat); end
        do_access(1, 1'b1, 1'b0, 32'h4, 32'h0, st, dat, e, rd, sa, dc);
        n_tests++; if (rd !== 32'h77) begin n_fail++; $display("FAIL l1_wrap_read: got %h expected 77", rd); end
        n_tests++; if (st !== 1) begin n_fail++; $display("FAIL l1_rd_stall: got %0d expected 1", st); end
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL l1_rd_err: got %b expected 0", e); end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        next_cycle();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_misaligned();
        test_conflict();
        test_reset_abort();
        test_latency1_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
